align_r_seq: RTL and testbench
==============================

Name: align_r_seq

Overview:
- Registered, handshaked read-data width converter between two bus widths that are both powers of two.
- Downsize (OUT narrower than IN): splits one wide beat into a burst of narrow beats, starting at the address-selected window.
- Upsize (OUT wider than IN): packs a burst of narrow beats into wide beats.
- Sits between cache/bus refill paths and narrower or wider consumers. Replaces purely combinational window selection where bursts and backpressure are needed.

Parameters:
- IN_P_DW_BYTES, 3, log2 of input data bytes.
- OUT_P_DW_BYTES, 2, log2 of output data bytes.
- IN_AW, 32, address width; must exceed max(IN_P_DW_BYTES, OUT_P_DW_BYTES).
- Derived: WIN_P_NUM = |IN_P_DW_BYTES - OUT_P_DW_BYTES|; WIN_NUM = 1<<WIN_P_NUM; LEN_W = max(WIN_P_NUM, 1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts input beat.
- i_dat  in  (1<<IN_P_DW_BYTES)*8  input data.
- i_be  in  1<<IN_P_DW_BYTES  input byte enables.
- i_addr  in  IN_AW  byte address of beat; sampled on the accepted beat.
- i_len  in  LEN_W  downsize only: narrow beats to emit, minus one. Ignored otherwise.
- i_last  in  1  input beat ends burst.
- o_valid  out  1  output beat valid.
- i_ready  in  1  consumer accepts output beat.
- o_dat  out  (1<<OUT_P_DW_BYTES)*8  output data.
- o_be  out  1<<OUT_P_DW_BYTES  output byte enables.
- o_last  out  1  output beat ends burst.

Behaviour:
- Handshake: transfer on valid & ready at a rising edge. o_valid never drops, and o_dat/o_be/o_last never change, until the beat is accepted. o_ready never depends combinationally on i_valid.
- Reset (rst_n low, immediate): o_valid=0, o_last=0, o_dat=0, o_be=0, o_ready=1. Counters and accumulator are cleared. A burst in progress is discarded; the output bus is idle on rst_n release.
- Equal widths: one-entry register slice. Latency 1. o_ready = !o_valid | i_ready, giving full throughput back-to-back.
- Downsize, FSM IDLE/SPLIT:
  - IDLE: o_ready=1. On accept, latch i_dat/i_be/i_last; set idx = i_addr[OUT_P_DW_BYTES +: WIN_P_NUM] and cnt = i_len; go to SPLIT.
  - SPLIT: o_valid=1. o_dat/o_be = window idx of the latched beat. o_last = latched i_last & (cnt==0).
  - On output accept with cnt!=0: idx = idx+1 modulo WIN_NUM (wraps WIN_NUM-1 -> 0), cnt-1.
  - On output accept with cnt==0: go to IDLE.
  - o_ready also =1 in SPLIT when cnt==0 & i_ready, so a new wide beat loads in the same cycle (no bubble).
  - Latency 1 cycle from input accept to first narrow beat.
  - i_len > WIN_NUM-1 is impossible by width, so no re-read of a window occurs.
- Upsize, FSM FILL/FULL:
  - FILL: o_ready=1. First beat of a burst (after reset, or after a beat carrying i_last) loads idx from i_addr[IN_P_DW_BYTES +: WIN_P_NUM]. Later beats use the running idx.
  - Each accepted beat writes i_dat into accumulator window idx and ORs i_be into be window idx. Windows not written in the current wide beat hold be=0; their data is don't-care, driven as 0.
  - Go to FULL when idx==WIN_NUM-1 or i_last. Otherwise idx+1.
  - FULL: o_valid=1, o_last = latched i_last. On output accept: clear accumulator, idx=0 (or reload on next burst start), back to FILL.
  - o_ready in FULL = i_ready, and the simultaneous input beat lands in the cleared accumulator. A burst crossing a wide boundary without i_last continues at idx 0.
  - Latency 1 cycle after the completing narrow beat.
- i_addr low bits below the window field are ignored in all modes.

Decomposition:
- Shared config header: mode-select constants (MODE_EQ/MODE_DN/MODE_UP) and clog2/max helper macros used for derived widths.
- Sub-module align_win_sel: combinational WIN_NUM-way window mux of data+be, instantiated by downsize. Upsize uses a generate-loop window write-enable decode.

Test Plan:
- Downsize 8->4 bytes: i_dat=0x1122334455667788, i_be=0xFF, i_addr=0x4, i_len=1, i_last=1 -> beat 0x11223344 be=0xF last=0, then 0x55667788 be=0xF last=1 (wrap 1->0).
- Downsize back-to-back with i_ready held 1: two wide beats, i_len=1 each -> 4 consecutive o_valid cycles, o_ready=1 on each cnt==0 cycle, no bubble.
- Downsize backpressure: i_ready=0 for 5 cycles mid-burst -> o_dat/o_be/o_last stable, o_ready=0, no beat lost or duplicated.
- Upsize 4->8 bytes: beats 0xAAAAAAAA (addr 0x0), 0xBBBBBBBB, i_last on second -> one beat 0xBBBBBBBBAAAAAAAA be=0xFF last=1.
- Upsize partial: single beat 0xCCCCCCCC addr 0x4 i_last=1 -> o_dat=0xCCCCCCCC00000000 be=0xF0 last=1.
- Reset mid-burst: rst_n low during downsize SPLIT with cnt=1 -> o_valid=0 immediately (asynchronous). After release, the next wide beat starts at its own i_addr window.

Source files
------------

// File: rtl/align_r_seq_pkg.sv
// Shared types and width helpers for the align_r_seq read-data width converter.
package align_r_seq_pkg;

  typedef enum logic [1:0] {ModeEq, ModeDn, ModeUp} mode_e;

  typedef enum logic {StIdle, StSplit} dn_state_e;
  typedef enum logic {StFill, StFull} up_state_e;

  function automatic mode_e mode_of(input int unsigned in_p, input int unsigned out_p);
    if (in_p > out_p) return ModeDn;
    if (in_p < out_p) return ModeUp;
    return ModeEq;
  endfunction

  function automatic int unsigned win_p_num(input int unsigned in_p, input int unsigned out_p);
    return (in_p > out_p) ? (in_p - out_p) : (out_p - in_p);
  endfunction

  function automatic int unsigned max1(input int unsigned x);
    return (x > 1) ? x : 1;
  endfunction

endpackage

// File: rtl/align_win_sel.sv
// Combinational window mux: picks one narrow data/byte-enable window out of a wide beat.
module align_win_sel #(
  parameter int unsigned NARROW_P  = 2,
  parameter int unsigned WIN_P_NUM = 1
) (
  input  logic [(1<<(NARROW_P+WIN_P_NUM))*8-1:0] i_dat,
  input  logic [(1<<(NARROW_P+WIN_P_NUM))-1:0]   i_be,
  input  logic [WIN_P_NUM-1:0]                   i_sel,
  output logic [(1<<NARROW_P)*8-1:0]             o_dat,
  output logic [(1<<NARROW_P)-1:0]               o_be
);

  localparam int unsigned NB      = 1 << NARROW_P;
  localparam int unsigned NW      = NB * 8;
  localparam int unsigned WIN_NUM = 1 << WIN_P_NUM;

  always_comb begin
    o_dat = '0;
    o_be  = '0;
    for (int w = 0; w < WIN_NUM; w++) begin
      if (i_sel == WIN_P_NUM'(w)) begin
        o_dat = i_dat[w*NW +: NW];
        o_be  = i_be[w*NB +: NB];
      end
    end
  end

endmodule

// File: rtl/align_r_seq.sv
// Registered, handshaked read-data width converter: register slice, burst splitter
// (downsize) or beat packer (upsize), selected by the relative bus widths.
module align_r_seq
  import align_r_seq_pkg::*;
#(
  parameter int unsigned IN_P_DW_BYTES  = 3,
  parameter int unsigned OUT_P_DW_BYTES = 2,
  parameter int unsigned IN_AW          = 32
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  i_valid,
  output logic                                                  o_ready,
  input  logic [(1<<IN_P_DW_BYTES)*8-1:0]                       i_dat,
  input  logic [(1<<IN_P_DW_BYTES)-1:0]                         i_be,
  input  logic [IN_AW-1:0]                                      i_addr,
  input  logic [max1(win_p_num(IN_P_DW_BYTES, OUT_P_DW_BYTES))-1:0] i_len,
  input  logic                                                  i_last,
  output logic                                                  o_valid,
  input  logic                                                  i_ready,
  output logic [(1<<OUT_P_DW_BYTES)*8-1:0]                      o_dat,
  output logic [(1<<OUT_P_DW_BYTES)-1:0]                        o_be,
  output logic                                                  o_last
);

  localparam mode_e       MODE      = mode_of(IN_P_DW_BYTES, OUT_P_DW_BYTES);
  localparam int unsigned WIN_P_NUM = win_p_num(IN_P_DW_BYTES, OUT_P_DW_BYTES);
  localparam int unsigned WIN_NUM   = 1 << WIN_P_NUM;
  localparam int unsigned LEN_W     = max1(WIN_P_NUM);
  localparam int unsigned IB        = 1 << IN_P_DW_BYTES;
  localparam int unsigned IW        = IB * 8;
  localparam int unsigned OB        = 1 << OUT_P_DW_BYTES;
  localparam int unsigned OW        = OB * 8;

  if (MODE == ModeEq) begin : g_eq
    logic          valid_q, last_q;
    logic [OW-1:0] dat_q;
    logic [OB-1:0] be_q;

    assign o_ready = !valid_q | i_ready;
    assign o_valid = valid_q;
    assign o_dat   = dat_q;
    assign o_be    = be_q;
    assign o_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        dat_q   <= '0;
        be_q    <= '0;
      end else if (i_valid && o_ready) begin
        valid_q <= 1'b1;
        last_q  <= i_last;
        dat_q   <= i_dat;
        be_q    <= i_be;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end

  end else if (MODE == ModeDn) begin : g_dn
    dn_state_e            state_q;
    logic [IW-1:0]        dat_q;
    logic [IB-1:0]        be_q;
    logic                 last_q;
    logic [WIN_P_NUM-1:0] idx_q;
    logic [LEN_W-1:0]     cnt_q;
    logic                 cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    assign o_valid  = (state_q == StSplit);
    // Last narrow beat frees the holding register, so a new wide beat can load with no bubble.
    assign o_ready  = (state_q == StIdle) | (cnt_zero & i_ready);
    assign o_last   = o_valid & last_q & cnt_zero;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        dat_q   <= '0;
        be_q    <= '0;
        last_q  <= 1'b0;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else if (o_valid && i_ready && !cnt_zero) begin
        idx_q <= idx_q + 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end else if (o_ready) begin
        if (i_valid) begin
          state_q <= StSplit;
          dat_q   <= i_dat;
          be_q    <= i_be;
          last_q  <= i_last;
          idx_q   <= i_addr[OUT_P_DW_BYTES +: WIN_P_NUM];
          cnt_q   <= i_len;
        end else begin
          state_q <= StIdle;
        end
      end
    end

    align_win_sel #(
      .NARROW_P  (OUT_P_DW_BYTES),
      .WIN_P_NUM (WIN_P_NUM)
    ) u_win_sel (
      .i_dat (dat_q),
      .i_be  (be_q),
      .i_sel (idx_q),
      .o_dat (o_dat),
      .o_be  (o_be)
    );

  end else begin : g_up
    up_state_e            state_q;
    logic                 first_q, last_q;
    logic [WIN_P_NUM-1:0] idx_q, wr_idx;
    logic [OW-1:0]        acc_dat_q, acc_dat_d;
    logic [OB-1:0]        acc_be_q, acc_be_d;
    logic [WIN_NUM-1:0]   wr_en;
    logic                 in_acc, out_acc;

    assign o_valid = (state_q == StFull);
    assign o_ready = (state_q == StFill) | i_ready;
    assign o_dat   = acc_dat_q;
    assign o_be    = acc_be_q;
    assign o_last  = o_valid & last_q;
    assign in_acc  = i_valid & o_ready;
    assign out_acc = o_valid & i_ready;
    assign wr_idx  = first_q ? i_addr[IN_P_DW_BYTES +: WIN_P_NUM] : idx_q;

    for (genvar w = 0; w < WIN_NUM; w++) begin : g_wr_en
      assign wr_en[w] = in_acc & (wr_idx == WIN_P_NUM'(w));
    end

    // A beat accepted while the full word drains lands in the freshly cleared accumulator.
    always_comb begin
      acc_dat_d = out_acc ? '0 : acc_dat_q;
      acc_be_d  = out_acc ? '0 : acc_be_q;
      for (int w = 0; w < WIN_NUM; w++) begin
        if (wr_en[w]) begin
          acc_dat_d[w*IW +: IW] = i_dat;
          acc_be_d[w*IB +: IB]  = acc_be_d[w*IB +: IB] | i_be;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StFill;
        first_q   <= 1'b1;
        last_q    <= 1'b0;
        idx_q     <= '0;
        acc_dat_q <= '0;
        acc_be_q  <= '0;
      end else begin
        acc_dat_q <= acc_dat_d;
        acc_be_q  <= acc_be_d;
        if (out_acc) state_q <= StFill;
        if (in_acc) begin
          idx_q   <= wr_idx + 1'b1;
          first_q <= i_last;
          last_q  <= i_last;
          if (i_last || (wr_idx == '1)) state_q <= StFull;
        end
      end
    end
  end

endmodule

// File: tb/tb_align_r_seq.sv
// Directed bench: one downsizing (8->4 bytes) and one upsizing (4->8 bytes) instance.
module tb_align_r_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Downsize instance: 64-bit in, 32-bit out.
  logic        dn_i_valid, dn_o_ready, dn_i_last, dn_o_valid, dn_i_ready, dn_o_last;
  logic [63:0] dn_i_dat;
  logic [7:0]  dn_i_be;
  logic [31:0] dn_i_addr;
  logic [0:0]  dn_i_len;
  logic [31:0] dn_o_dat;
  logic [3:0]  dn_o_be;

  // Upsize instance: 32-bit in, 64-bit out.
  logic        up_i_valid, up_o_ready, up_i_last, up_o_valid, up_i_ready, up_o_last;
  logic [31:0] up_i_dat;
  logic [3:0]  up_i_be;
  logic [31:0] up_i_addr;
  logic [0:0]  up_i_len;
  logic [63:0] up_o_dat;
  logic [7:0]  up_o_be;

  align_r_seq #(.IN_P_DW_BYTES(3), .OUT_P_DW_BYTES(2), .IN_AW(32)) u_dn (
    .clk(clk), .rst_n(rst_n), .i_valid(dn_i_valid), .o_ready(dn_o_ready), .i_dat(dn_i_dat),
    .i_be(dn_i_be), .i_addr(dn_i_addr), .i_len(dn_i_len), .i_last(dn_i_last),
    .o_valid(dn_o_valid), .i_ready(dn_i_ready), .o_dat(dn_o_dat), .o_be(dn_o_be),
    .o_last(dn_o_last)
  );

  align_r_seq #(.IN_P_DW_BYTES(2), .OUT_P_DW_BYTES(3), .IN_AW(32)) u_up (
    .clk(clk), .rst_n(rst_n), .i_valid(up_i_valid), .o_ready(up_o_ready), .i_dat(up_i_dat),
    .i_be(up_i_be), .i_addr(up_i_addr), .i_len(up_i_len), .i_last(up_i_last),
    .o_valid(up_o_valid), .i_ready(up_i_ready), .o_dat(up_o_dat), .o_be(up_o_be),
    .o_last(up_o_last)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dn_drive(input logic [63:0] dat, input logic [31:0] addr, input logic len,
                          input logic last);
    dn_i_valid = 1'b1;
    dn_i_dat   = dat;
    dn_i_be    = 8'hFF;
    dn_i_addr  = addr;
    dn_i_len   = len;
    dn_i_last  = last;
  endtask

  task automatic dn_expect(input string tag, input logic [31:0] dat, input logic last);
    check({tag, ".valid"}, 64'(dn_o_valid), 64'd1);
    check({tag, ".dat"},   64'(dn_o_dat),   64'(dat));
    check({tag, ".be"},    64'(dn_o_be),    64'hF);
    check({tag, ".last"},  64'(dn_o_last),  64'(last));
  endtask

  task automatic up_drive(input logic [31:0] dat, input logic [31:0] addr, input logic last);
    up_i_valid = 1'b1;
    up_i_dat   = dat;
    up_i_be    = 4'hF;
    up_i_addr  = addr;
    up_i_last  = last;
  endtask

  task automatic up_expect(input string tag, input logic [63:0] dat, input logic [7:0] be,
                           input logic last);
    check({tag, ".valid"}, 64'(up_o_valid), 64'd1);
    check({tag, ".dat"},   up_o_dat,        dat);
    check({tag, ".be"},    64'(up_o_be),    64'(be));
    check({tag, ".last"},  64'(up_o_last),  64'(last));
  endtask

  initial begin
    rst_n      = 1'b0;
    dn_i_valid = 1'b0; dn_i_dat = '0; dn_i_be = '0; dn_i_addr = '0; dn_i_len = '0;
    dn_i_last  = 1'b0; dn_i_ready = 1'b0;
    up_i_valid = 1'b0; up_i_dat = '0; up_i_be = '0; up_i_addr = '0; up_i_len = '0;
    up_i_last  = 1'b0; up_i_ready = 1'b0;
    #23;
    check("rst.dn_valid", 64'(dn_o_valid), 64'd0);
    check("rst.dn_ready", 64'(dn_o_ready), 64'd1);
    check("rst.dn_dat",   64'(dn_o_dat),   64'd0);
    check("rst.dn_be",    64'(dn_o_be),    64'd0);
    check("rst.dn_last",  64'(dn_o_last),  64'd0);
    check("rst.up_valid", 64'(up_o_valid), 64'd0);
    check("rst.up_ready", 64'(up_o_ready), 64'd1);
    check("rst.up_dat",   up_o_dat,        64'd0);
    rst_n = 1'b1;
    step();

    // Downsize: address window 1 first, then wrap to window 0.
    dn_drive(64'h1122334455667788, 32'h4, 1'b1, 1'b1);
    step();
    dn_i_valid = 1'b0;
    dn_expect("dn1.b0", 32'h11223344, 1'b0);
    check("dn1.ready_busy", 64'(dn_o_ready), 64'd0);
    dn_i_ready = 1'b1;
    step();
    dn_expect("dn1.b1", 32'h55667788, 1'b1);
    check("dn1.ready_cnt0", 64'(dn_o_ready), 64'd1);
    step();
    check("dn1.idle", 64'(dn_o_valid), 64'd0);

    // Downsize back-to-back: second wide beat loads on the cnt==0 cycle, no bubble.
    dn_drive(64'hA0A1A2A3B0B1B2B3, 32'h0, 1'b1, 1'b0);
    step();
    dn_expect("dn2.b0", 32'hB0B1B2B3, 1'b0);
    dn_drive(64'hC0C1C2C3D0D1D2D3, 32'h4, 1'b1, 1'b1);
    step();
    dn_expect("dn2.b1", 32'hA0A1A2A3, 1'b0);
    check("dn2.ready_cnt0", 64'(dn_o_ready), 64'd1);
    step();
    dn_i_valid = 1'b0;
    dn_expect("dn2.b2", 32'hC0C1C2C3, 1'b0);
    step();
    dn_expect("dn2.b3", 32'hD0D1D2D3, 1'b1);
    step();
    check("dn2.idle", 64'(dn_o_valid), 64'd0);

    // Downsize backpressure: outputs frozen while the consumer stalls.
    dn_i_ready = 1'b0;
    dn_drive(64'h0102030405060708, 32'h0, 1'b1, 1'b1);
    step();
    dn_i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dn_expect("dn3.stall", 32'h05060708, 1'b0);
      check("dn3.ready", 64'(dn_o_ready), 64'd0);
      step();
    end
    dn_i_ready = 1'b1;
    step();
    dn_expect("dn3.b1", 32'h01020304, 1'b1);
    step();
    check("dn3.idle", 64'(dn_o_valid), 64'd0);

    // Reset mid-burst is immediate; the next beat starts at its own window.
    dn_i_ready = 1'b0;
    dn_drive(64'h1122334455667788, 32'h0, 1'b1, 1'b1);
    step();
    dn_i_valid = 1'b0;
    dn_expect("rst2.pre", 32'h55667788, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst2.valid", 64'(dn_o_valid), 64'd0);
    check("rst2.dat",   64'(dn_o_dat),   64'd0);
    check("rst2.ready", 64'(dn_o_ready), 64'd1);
    #3 rst_n = 1'b1;
    step();
    check("rst2.idle", 64'(dn_o_valid), 64'd0);
    dn_i_ready = 1'b1;
    dn_drive(64'h99AABBCCDDEEFF00, 32'h4, 1'b0, 1'b1);
    step();
    dn_i_valid = 1'b0;
    dn_expect("rst2.post", 32'h99AABBCC, 1'b1);

    // Upsize: two narrow beats packed into one wide beat.
    up_i_ready = 1'b0;
    up_drive(32'hAAAAAAAA, 32'h0, 1'b0);
    step();
    up_drive(32'hBBBBBBBB, 32'h0, 1'b1);
    step();
    up_i_valid = 1'b0;
    up_expect("up1", 64'hBBBBBBBBAAAAAAAA, 8'hFF, 1'b1);
    check("up1.ready", 64'(up_o_ready), 64'd0);
    up_i_ready = 1'b1;
    step();
    check("up1.drain", 64'(up_o_valid), 64'd0);

    // Upsize partial: upper window only.
    up_drive(32'hCCCCCCCC, 32'h4, 1'b1);
    step();
    up_expect("up2", 64'hCCCCCCCC00000000, 8'hF0, 1'b1);
    // New burst accepted in the same cycle the full word drains.
    up_drive(32'hDDDDDDDD, 32'h0, 1'b0);
    step();
    check("up3.fill", 64'(up_o_valid), 64'd0);
    up_drive(32'hEEEEEEEE, 32'h0, 1'b0);
    step();
    // Burst continues past the wide boundary at window 0; its address is ignored.
    up_drive(32'h12345678, 32'h4, 1'b1);
    up_expect("up3", 64'hEEEEEEEEDDDDDDDD, 8'hFF, 1'b0);
    step();
    up_i_valid = 1'b0;
    up_expect("up4", 64'h0000000012345678, 8'h0F, 1'b1);
    step();
    check("up4.drain", 64'(up_o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
